// File: rtl/rv_pkg.sv
// Shared constants and clear-walk state encoding for the multi-port register file.
//   XLEN_DEF    : default data width
//   NREG_DEF    : default register count
//   clr_state_e : background-clear FSM state (IDLE=0, WALK=1)
package rv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, scoreboard set and bulk clear.
//   raddr/rdata/rbusy : NRD packed read ports (address, data, scoreboard busy)
//   wen/waddr/wdata   : NWR packed write ports
//   sb_set/sb_addr    : mark one register busy
//   clr_req/clr_busy  : start / observe a background clear walk
//   master = requester side, slave = register file side
interface regfile_mp_if #(
  parameter int unsigned XLEN = rv_pkg::XLEN_DEF,
  parameter int unsigned NREG = rv_pkg::NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
);

  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                clr_req;
  logic                clr_busy;

  modport master (
    output raddr, wen, waddr, wdata, sb_set, sb_addr, clr_req,
    input  rdata, rbusy, clr_busy
  );

  modport slave (
    input  raddr, wen, waddr, wdata, sb_set, sb_addr, clr_req,
    output rdata, rbusy, clr_busy
  );

endinterface

// File: rtl/regfile_wsel.sv
// Read-port data select: stored value, optionally overridden by a same-cycle write.
//   raddr  : read address of this port
//   stored : register contents at raddr
//   wen/waddr/wdata : packed write ports (higher port index has priority)
//   rdata  : data returned to the reader (always 0 for address 0)
module regfile_wsel #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [AW-1:0]       raddr,
  input  logic [XLEN-1:0]     stored,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  output logic [XLEN-1:0]     rdata
);

  // Later ports overwrite earlier matches so the highest-index writer wins.
  always_comb begin
    rdata = stored;
    if (BYPASS) begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wen[p] && (waddr[p*AW +: AW] == raddr)) begin
          rdata = wdata[p*XLEN +: XLEN];
        end
      end
    end
    if (raddr == '0) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and background clear walk.
//   clk  : rising-edge clock
//   arst : asynchronous active-high reset
//   bus  : regfile_mp_if slave (read/write ports, scoreboard set, clear request/status)
// Register 0 is hardwired to zero. The clear walk zeroes x1..x(NREG-1), one per
// cycle, while ordinary writes keep working and win over the walk's zero.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input logic         clk,
  input logic         arst,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  clr_state_e      state;
  clr_state_e      state_next;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_next;
  logic            walk_entry;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic [NWR-1:0]  wen_live;
  logic [XLEN-1:0] regs [NREG];

  // Writers are not visible to readers while reset is held.
  assign wen_live = arst ? '0 : bus.wen;

  // Clear-walk state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Clear-walk next state: walk starts at x1 and ends after clearing x(NREG-1).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    walk_entry = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_next = WALK;
          cnt_next   = AW'(1);
          walk_entry = 1'b1;
        end
      end
      WALK: begin
        cnt_next = cnt + AW'(1);
        if (cnt == AW'(NREG - 1)) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  assign bus.clr_busy = (state == WALK);

  // Scoreboard next value: bulk clear or per-write clears, then set has the final say.
  always_comb begin
    sb_next = sb;
    if (walk_entry) begin
      sb_next = '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (bus.wen[p]) begin
          sb_next[bus.waddr[p*AW +: AW]] = 1'b0;
        end
      end
    end
    if (bus.sb_set) begin
      sb_next[bus.sb_addr] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  // Register array: walk zero first, then ports in ascending order so port writes win.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (state == WALK) begin
        regs[cnt] <= '0;
      end
      for (int unsigned p = 0; p < NWR; p++) begin
        if (bus.wen[p] && (bus.waddr[p*AW +: AW] != '0)) begin
          regs[bus.waddr[p*AW +: AW]] <= bus.wdata[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: busy bit straight from the stored scoreboard, data through the bypass select.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;

    assign ra           = bus.raddr[p*AW +: AW];
    assign bus.rbusy[p] = sb[ra];

    regfile_wsel #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_wsel (
      .raddr  (ra),
      .stored (regs[ra]),
      .wen    (wen_live),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .rdata  (bus.rdata[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one BYPASS=1 and one BYPASS=0 instance
// driven with identical stimulus and compared against a behavioural model.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;
  localparam int unsigned AW   = 5;

  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus0 ();

  assign bus0.raddr   = bus.raddr;
  assign bus0.wen     = bus.wen;
  assign bus0.waddr   = bus.waddr;
  assign bus0.wdata   = bus.wdata;
  assign bus0.sb_set  = bus.sb_set;
  assign bus0.sb_addr = bus.sb_addr;
  assign bus0.clr_req = bus.clr_req;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) dut0 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus0.slave)
  );

  // Reference model: architectural register values, busy bits, and the list of
  // registers a clear still has to zero (one per cycle, lowest first).
  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_sb;
  int              m_walk_q [$];

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rd(input bit nobyp, input int p);
    return nobyp ? bus0.rdata[p*XLEN +: XLEN] : bus.rdata[p*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (a == '0) return '0;
    v = m_regs[a];
    if (byp && !arst) begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wen[p] && bus.waddr[p*AW +: AW] == a) v = bus.wdata[p*XLEN +: XLEN];
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < NREG; a++) m_regs[a] = '0;
    m_sb = '0;
    m_walk_q.delete();
  endtask

  // Applies one clock edge's worth of architectural effect from the current inputs.
  task automatic model_edge();
    bit walking;
    int a;
    if (arst) return;
    walking = (m_walk_q.size() != 0);
    if (walking) begin
      a = m_walk_q.pop_front();
      m_regs[a] = '0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (bus.wen[p] && bus.waddr[p*AW +: AW] != '0)
        m_regs[bus.waddr[p*AW +: AW]] = bus.wdata[p*XLEN +: XLEN];
    end
    if (!walking && bus.clr_req) begin
      m_sb = '0;
      for (int r = 1; r < NREG; r++) m_walk_q.push_back(r);
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wen[p]) m_sb[bus.waddr[p*AW +: AW]] = 1'b0;
      end
    end
    if (bus.sb_set && bus.sb_addr != '0) m_sb[bus.sb_addr] = 1'b1;
  endtask

  task automatic check_outputs();
    logic [AW-1:0] a;
    for (int p = 0; p < NRD; p++) begin
      a = bus.raddr[p*AW +: AW];
      check($sformatf("rdata%0d_byp x%0d", p, a), rd(1'b0, p), exp_read(a, 1'b1));
      check($sformatf("rdata%0d_nobyp x%0d", p, a), rd(1'b1, p), exp_read(a, 1'b0));
      check($sformatf("rbusy%0d x%0d", p, a), XLEN'(bus.rbusy[p]), XLEN'(m_sb[a]));
    end
    check("clr_busy", XLEN'(bus.clr_busy), XLEN'(m_walk_q.size() != 0));
    check("clr_busy_nobyp", XLEN'(bus0.clr_busy), XLEN'(m_walk_q.size() != 0));
  endtask

  // One clock: check combinational outputs mid-cycle, step model on the edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.wen     = '0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.sb_set  = 1'b0;
    bus.sb_addr = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    bus.wen[p]                = 1'b1;
    bus.waddr[p*AW +: AW]     = AW'(a);
    bus.wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_raddr(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic fill();
    for (int a = 1; a < NREG; a++) begin
      idle_inputs();
      wr(0, a, $urandom | 32'h1);
      if (a % 3 == 0) begin
        bus.sb_set  = 1'b1;
        bus.sb_addr = AW'(a);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int guard;
    n_tests = 0;
    n_fail  = 0;
    arst    = 1'b1;
    idle_inputs();
    bus.raddr = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    set_raddr(0, 5);
    set_raddr(1, 31);
    #1;
    check("reset clr_busy", XLEN'(bus.clr_busy), '0);
    check("reset x5", rd(1'b0, 0), '0);
    check("reset x31", rd(1'b0, 1), '0);
    arst = 1'b0;
    cycle();

    // Write x5 on port 0, read on both ports same cycle and next
    idle_inputs();
    wr(0, 5, 32'hDEADBEEF);
    set_raddr(0, 5);
    set_raddr(1, 5);
    #1;
    check("bypass same cycle p0", rd(1'b0, 0), 32'hDEADBEEF);
    check("bypass same cycle p1", rd(1'b0, 1), 32'hDEADBEEF);
    check("no bypass same cycle", rd(1'b1, 0), 32'h0);
    cycle();
    idle_inputs();
    #1;
    check("bypass next cycle", rd(1'b0, 1), 32'hDEADBEEF);
    check("no bypass next cycle", rd(1'b1, 1), 32'hDEADBEEF);
    cycle();

    // Same-address double write and write to x0
    idle_inputs();
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    cycle();
    idle_inputs();
    wr(0, 0, 32'hFF);
    cycle();
    idle_inputs();
    set_raddr(0, 7);
    set_raddr(1, 0);
    #1;
    check("port1 wins x7", rd(1'b0, 0), 32'h22);
    check("port1 wins x7 nobyp", rd(1'b1, 0), 32'h22);
    check("x0 reads zero", rd(1'b0, 1), 32'h0);
    cycle();

    // Scoreboard set vs write clear
    idle_inputs();
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(9);
    cycle();
    wr(0, 9, 32'h99);
    cycle();
    idle_inputs();
    set_raddr(0, 9);
    #1;
    check("set beats clear x9", XLEN'(bus.rbusy[0]), 32'h1);
    wr(0, 9, 32'h9A);
    cycle();
    idle_inputs();
    #1;
    check("write clears x9", XLEN'(bus.rbusy[0]), 32'h0);
    cycle();

    // Full clear walk
    fill();
    bus.clr_req = 1'b1;
    cycle();
    idle_inputs();
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.clr_busy) busy_cnt++;
      cycle();
    end
    check("clear walk cycles", XLEN'(busy_cnt), 32'd31);
    for (int a = 0; a < NREG; a++) begin
      set_raddr(0, a);
      set_raddr(1, NREG - 1 - a);
      #1;
      check($sformatf("cleared x%0d", a), rd(1'b0, 0), 32'h0);
      check($sformatf("sb cleared x%0d", a), XLEN'(bus.rbusy[0]), 32'h0);
      cycle();
    end

    // Writes racing the walk
    fill();
    bus.clr_req = 1'b1;
    cycle();
    idle_inputs();
    repeat (9) cycle();
    wr(0, 10, 32'hA);
    wr(1, 20, 32'hC);
    cycle();
    idle_inputs();
    wr(0, 3, 32'hB);
    cycle();
    idle_inputs();
    guard = 0;
    while (bus.clr_busy && guard < 40) begin
      cycle();
      guard++;
    end
    check("walk finished", XLEN'(bus.clr_busy), 32'h0);
    set_raddr(0, 10);
    set_raddr(1, 3);
    #1;
    check("x10 write at cnt", rd(1'b0, 0), 32'hA);
    check("x3 below cnt kept", rd(1'b0, 1), 32'hB);
    set_raddr(1, 20);
    #1;
    check("x20 above cnt cleared", rd(1'b0, 1), 32'h0);
    cycle();

    // Async reset in the middle of a walk
    fill();
    bus.clr_req = 1'b1;
    cycle();
    idle_inputs();
    repeat (11) cycle();
    #2;
    arst = 1'b1;
    #1;
    check("reset drops clr_busy", XLEN'(bus.clr_busy), 32'h0);
    model_reset();
    set_raddr(0, 12);
    set_raddr(1, 30);
    wr(0, 12, 32'h1234);
    bus.clr_req = 1'b1;
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(12);
    #1;
    check("reset x12 ignores bypass", rd(1'b0, 0), 32'h0);
    check("reset x30", rd(1'b0, 1), 32'h0);
    cycle();
    cycle();
    #2;
    idle_inputs();
    arst = 1'b0;
    repeat (3) cycle();
    check("no walk after reset", XLEN'(bus.clr_busy), 32'h0);

    // Randomized traffic, including clears and writes during walks
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 2) != 0) wr(p, $urandom_range(0, NREG - 1), $urandom);
      end
      for (int p = 0; p < NRD; p++) set_raddr(p, $urandom_range(0, NREG - 1));
      if ($urandom_range(0, 1) != 0) set_raddr(0, int'(bus.waddr[AW-1:0]));
      if ($urandom_range(0, 1) != 0) set_raddr(1, int'(bus.waddr[2*AW-1:AW]));
      bus.sb_set  = ($urandom_range(0, 3) == 0);
      bus.sb_addr = AW'($urandom_range(0, NREG - 1));
      bus.clr_req = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
